cic_interp_filter: RTL and testbench

//  N-stage CIC interpolation filter, the transmit-side counterpart of the CIC decimator.

---
 rtl/cic_interp_filter_if.sv | 24 ++
 rtl/cic_interp_filter.sv | 142 ++++++++++++++
 tb/tb_cic_interp_filter.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/cic_interp_filter_if.sv
// Sample-stream bundle of the CIC interpolator: low-rate samples in, bursts of
// interpolated samples out, plus the rate code and the sticky overrun flag.
interface cic_interp_filter_if #(
    parameter int InDataWidth  = 14,
    parameter int OutDataWidth = 28
);
    logic [2:0]              InterpFactor_i;
    logic [InDataWidth-1:0]  Data_i;
    logic                    DataNd_i;
    logic                    Ready_o;
    logic [OutDataWidth-1:0] Data_o;
    logic                    DataValid_o;
    logic                    OvrErr_o;

    modport master (
        output InterpFactor_i, Data_i, DataNd_i,
        input  Ready_o, Data_o, DataValid_o, OvrErr_o
    );

    modport slave (
        input  InterpFactor_i, Data_i, DataNd_i,
        output Ready_o, Data_o, DataValid_o, OvrErr_o
    );
endinterface

// File: rtl/cic_interp_filter.sv
// N-stage CIC interpolator: comb chain at the input rate, zero-stuffing burst
// upsampler (x R), then an integrator chain running at the clock rate.
module cic_interp_filter #(
    parameter int N              = 2,
    parameter int M              = 1,
    parameter int InDataWidth    = 14,
    parameter int OutDataWidth   = 28,
    parameter int InterpCntWidth = 7
) (
    input logic Clk_i,
    input logic Rst_i,
    cic_interp_filter_if.slave bus
);
    typedef logic signed [OutDataWidth-1:0] sampleT;
    typedef enum logic {IDLE, BURST} stateE;

    stateE                     state, stateNxt;
    logic [InterpCntWidth-1:0] cnt, cntNxt, lastCnt, lastCntNxt;
    logic [2:0]                codeSat;

    sampleT       combIn  [N];
    sampleT       combOut [N];
    sampleT       combDly [N][M];
    logic [N-1:0] combStb;
    logic [N-1:0] combVld;

    sampleT       usData;
    logic         usValid;
    sampleT       intIn  [N];
    sampleT       intAcc [N];
    logic [N-1:0] intInVld;
    logic [N-1:0] intVld;

    logic ready;
    logic accept;
    logic ovrErr;

    assign ready  = (state == IDLE) && (combVld == '0);
    assign accept = bus.DataNd_i && ready;

    always_comb begin
        combIn[0]  = sampleT'(signed'(bus.Data_i));
        combStb[0] = accept;
        for (int k = 1; k < N; k++) begin
            combIn[k]  = combOut[k-1];
            combStb[k] = combVld[k-1];
        end
    end

    // NOTE: <= throughout so every stage samples its neighbour's pre-edge value.
    always_ff @(posedge Clk_i or negedge Rst_i) begin
        if (!Rst_i) begin
            combVld <= '0;
            // NOTE: delay taps are plain registers and are cleared, else a stale
            // tap injects a spurious step into the first burst after reset.
            for (int k = 0; k < N; k++) begin
                combOut[k] <= '0;
                for (int j = 0; j < M; j++) combDly[k][j] <= '0;
            end
        end else begin
            for (int k = 0; k < N; k++) begin
                combVld[k] <= combStb[k];
                if (combStb[k]) begin
                    combOut[k]    <= combIn[k] - combDly[k][M-1];
                    combDly[k][0] <= combIn[k];
                    for (int j = 1; j < M; j++) combDly[k][j] <= combDly[k][j-1];
                end
            end
        end
    end

    // Codes above 6 saturate at R = 128.
    assign codeSat = (bus.InterpFactor_i == 3'd7) ? 3'd6 : bus.InterpFactor_i;

    always_ff @(posedge Clk_i or negedge Rst_i) begin
        if (!Rst_i) begin
            state   <= IDLE;
            cnt     <= '0;
            lastCnt <= '0;
        end else begin
            state   <= stateNxt;
            cnt     <= cntNxt;
            lastCnt <= lastCntNxt;
        end
    end

    always_comb begin
        // NOTE: defaults first, so no branch leaves a target unassigned (no latch).
        stateNxt   = state;
        cntNxt     = cnt;
        lastCntNxt = lastCnt;
        unique case (state)
            IDLE: begin
                if (combVld[N-1]) begin
                    stateNxt   = BURST;
                    cntNxt     = '0;
                    lastCntNxt = InterpCntWidth'((32'd1 << (32'(codeSat) + 32'd1)) - 32'd1);
                end
            end
            BURST: begin
                if (cnt == lastCnt) stateNxt = IDLE;
                else                cntNxt   = cnt + 1'b1;
            end
            default: stateNxt = IDLE;
        endcase
    end

    // The comb output is frozen for the whole burst because Ready_o is low.
    assign usValid = (state == BURST);
    assign usData  = (cnt == '0) ? combOut[N-1] : '0;

    always_comb begin
        intIn[0]    = usData;
        intInVld[0] = usValid;
        for (int k = 1; k < N; k++) begin
            intIn[k]    = intAcc[k-1];
            intInVld[k] = intVld[k-1];
        end
    end

    always_ff @(posedge Clk_i or negedge Rst_i) begin
        if (!Rst_i) begin
            intVld <= '0;
            for (int k = 0; k < N; k++) intAcc[k] <= '0;
        end else begin
            for (int k = 0; k < N; k++) begin
                intVld[k] <= intInVld[k];
                if (intInVld[k]) intAcc[k] <= intAcc[k] + intIn[k];
            end
        end
    end

    always_ff @(posedge Clk_i or negedge Rst_i) begin
        if (!Rst_i)                          ovrErr <= 1'b0;
        else if (bus.DataNd_i && !ready)     ovrErr <= 1'b1;
    end

    assign bus.Ready_o     = ready;
    assign bus.Data_o      = intAcc[N-1];
    assign bus.DataValid_o = intVld[N-1];
    assign bus.OvrErr_o    = ovrErr;
endmodule

// File: tb/tb_cic_interp_filter.sv
// Directed bench for cic_interp_filter: table of short sample streams with
// hand-computed outputs, plus overrun, rate-change, async-reset and random runs.
module tb_cic_interp_filter;
    localparam int N    = 2;
    localparam int M    = 1;
    localparam int InW  = 14;
    localparam int OutW = 28;
    localparam int CntW = 7;

    logic clk  = 1'b0;
    logic rstN = 1'b0;
    always #5 clk = ~clk;

    cic_interp_filter_if #(.InDataWidth(InW), .OutDataWidth(OutW)) bus ();

    cic_interp_filter #(
        .N(N), .M(M), .InDataWidth(InW), .OutDataWidth(OutW), .InterpCntWidth(CntW)
    ) dut (
        .Clk_i(clk),
        .Rst_i(rstN),
        .bus  (bus)
    );

    int testsRun = 0;
    int failed   = 0;

    longint outQ[$];
    int     cycQ[$];
    int     acceptQ[$];
    int     ncyc = 0;

    always @(negedge clk) begin
        ncyc++;
        if (rstN && bus.DataNd_i && bus.Ready_o) acceptQ.push_back(ncyc);
        if (rstN && bus.DataValid_o) begin
            outQ.push_back(longint'(signed'(bus.Data_o)));
            cycQ.push_back(ncyc);
        end
    end

    typedef struct {
        string      name;
        logic [2:0] code;
        int         nIn;
        int         din [4];
        int         expLen;
        int         expSeq [8];
        int         expLast;
    } vecT;

    vecT vecs [7];

    task automatic check(input string name, input longint act, input longint exp);
        testsRun++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic step(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic doReset();
        rstN = 1'b0;
        step(2);
        rstN = 1'b1;
        step(1);
    endtask

    task automatic sendSample(input int v);
        int w = 0;
        while (!bus.Ready_o && w < 400) begin
            step();
            w++;
        end
        if (!bus.Ready_o) begin
            check("ready_timeout", longint'(bus.Ready_o), 1);
            return;
        end
        bus.Data_i   = v[InW-1:0];
        bus.DataNd_i = 1'b1;
        step();
        bus.DataNd_i = 1'b0;
        bus.Data_i   = '0;
    endtask

    task automatic drain();
        int w = 0;
        while (!bus.Ready_o && w < 400) begin
            step();
            w++;
        end
        check("drain_ready", longint'(bus.Ready_o), 1);
        step(2 * N + 4);
    endtask

    function automatic longint wrapOut(input longint v);
        logic signed [OutW-1:0] t;
        t = v[OutW-1:0];
        return longint'(t);
    endfunction

    task automatic randomTest();
        longint p1, p2, i1, i2, c1, c2;
        longint expQ[$];
        int     base, n, x;
        p1 = 0; p2 = 0; i1 = 0; i2 = 0;
        doReset();
        bus.InterpFactor_i = 3'd2;
        base = outQ.size();
        for (int s = 0; s < 16; s++) begin
            if (s == 0)      x = -8192;
            else if (s == 1) x = 8191;
            else             x = int'($urandom_range(16383)) - 8192;
            c1 = x - p1;  p1 = x;
            c2 = c1 - p2; p2 = c1;
            for (int r = 0; r < 8; r++) begin
                i1 += (r == 0) ? c2 : 0;
                i2 += i1;
                expQ.push_back(i2);
            end
            sendSample(x);
        end
        drain();
        n = outQ.size() - base;
        check("rand_len", n, expQ.size());
        for (int i = 0; i < expQ.size(); i++)
            if (i < n) check($sformatf("rand_out%0d", i), wrapOut(outQ[base+i]), wrapOut(expQ[i]));
    endtask

    initial begin
        int base, abase, n;

        vecs[0] = '{"impulse_r2", 3'd0, 4, '{1, 0, 0, 0}, 8,
                    '{1, 2, 1, 0, 0, 0, 0, 0}, 0};
        vecs[1] = '{"dc1_r2", 3'd0, 4, '{1, 1, 1, 1}, 8,
                    '{1, 2, 2, 2, 2, 2, 2, 2}, 2};
        vecs[2] = '{"dc100_r8", 3'd2, 2, '{100, 100, 0, 0}, 16,
                    '{100, 200, 300, 400, 500, 600, 700, 800}, 800};
        vecs[3] = '{"negfs_r128", 3'd6, 2, '{-8192, -8192, 0, 0}, 256,
                    '{-8192, -16384, -24576, -32768, -40960, -49152, -57344, -65536}, -1048576};
        vecs[4] = '{"code7_r128", 3'd7, 1, '{3, 0, 0, 0}, 128,
                    '{3, 6, 9, 12, 15, 18, 21, 24}, 384};
        vecs[5] = '{"negimp_r4", 3'd1, 3, '{-5, 0, 0, 0}, 12,
                    '{-5, -10, -15, -20, -15, -10, -5, 0}, 0};
        vecs[6] = '{"posfs_r16", 3'd3, 1, '{8191, 0, 0, 0}, 16,
                    '{8191, 16382, 24573, 32764, 40955, 49146, 57337, 65528}, 131056};

        bus.InterpFactor_i = 3'd0;
        bus.Data_i         = '0;
        bus.DataNd_i       = 1'b0;

        // Held in reset with strobes toggling: nothing may move.
        for (int i = 0; i < 4; i++) begin
            bus.DataNd_i = ~bus.DataNd_i;
            bus.Data_i   = 14'h1234;
            step();
        end
        bus.DataNd_i = 1'b0;
        check("rst_ready", longint'(bus.Ready_o), 1);
        check("rst_valid", longint'(bus.DataValid_o), 0);
        check("rst_data",  longint'(bus.Data_o), 0);
        check("rst_ovr",   longint'(bus.OvrErr_o), 0);
        rstN = 1'b1;
        step(2);

        for (int v = 0; v < 7; v++) begin
            doReset();
            bus.InterpFactor_i = vecs[v].code;
            base  = outQ.size();
            abase = acceptQ.size();
            for (int i = 0; i < vecs[v].nIn; i++) sendSample(vecs[v].din[i]);
            drain();
            n = outQ.size() - base;
            check({vecs[v].name, "_len"}, n, vecs[v].expLen);
            for (int i = 0; i < 8; i++)
                if (i < n) check($sformatf("%s_out%0d", vecs[v].name, i), outQ[base+i], vecs[v].expSeq[i]);
            if (n > 0) begin
                check({vecs[v].name, "_last"}, outQ[outQ.size()-1], vecs[v].expLast);
                check({vecs[v].name, "_latency"}, cycQ[base] - acceptQ[abase], 2 * N + 1);
            end
        end

        // Rate code changed mid-burst: current burst keeps R=128, the next uses R=2.
        doReset();
        bus.InterpFactor_i = 3'd6;
        base = outQ.size();
        sendSample(5);
        step(20);
        bus.InterpFactor_i = 3'd0;
        drain();
        check("ratechg_len", outQ.size() - base, 128);
        base = outQ.size();
        sendSample(5);
        drain();
        check("ratechg_next_len", outQ.size() - base, 2);

        // Overrun one cycle after acceptance: dropped, flag sticks, stream unaffected.
        doReset();
        bus.InterpFactor_i = 3'd0;
        base = outQ.size();
        sendSample(7);
        check("ovr_ready_low", longint'(bus.Ready_o), 0);
        bus.Data_i   = 14'd99;
        bus.DataNd_i = 1'b1;
        step();
        bus.DataNd_i = 1'b0;
        bus.Data_i   = '0;
        check("ovr_flag", longint'(bus.OvrErr_o), 1);
        sendSample(0);
        drain();
        n = outQ.size() - base;
        check("ovr_len", n, 4);
        if (n >= 4) begin
            check("ovr_out0", outQ[base],   7);
            check("ovr_out1", outQ[base+1], 14);
            check("ovr_out2", outQ[base+2], 7);
            check("ovr_out3", outQ[base+3], 0);
        end
        check("ovr_sticky", longint'(bus.OvrErr_o), 1);

        // Async reset asserted mid-cycle during a burst.
        doReset();
        bus.InterpFactor_i = 3'd6;
        sendSample(5);
        bus.DataNd_i = 1'b1;
        step();
        bus.DataNd_i = 1'b0;
        step(10);
        check("pre_rst_valid", longint'(bus.DataValid_o), 1);
        check("pre_rst_ovr",   longint'(bus.OvrErr_o), 1);
        #3 rstN = 1'b0;
        #1;
        check("arst_valid", longint'(bus.DataValid_o), 0);
        check("arst_data",  longint'(bus.Data_o), 0);
        check("arst_ovr",   longint'(bus.OvrErr_o), 0);
        check("arst_ready", longint'(bus.Ready_o), 1);
        step(2);
        rstN = 1'b1;
        base = outQ.size();
        step(300);
        check("arst_no_outputs", outQ.size() - base, 0);

        randomTest();

        $display("[TB] %0d tests run, %0d failed", testsRun, failed);
        $finish;
    end
endmodule
